// File: rtl/data_mem_readback.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_readback
// Purpose  : After core_done, hold the core in test mode and stream a range of
//            data memory out as (address, word) pairs over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_readback #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              core_done,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       count,
    output logic              mem_test_normal,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              dump_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_rem;
    logic [ADDR_W-1:0] r_mem_rd_addr;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_busy;
    logic              r_test_normal;
    logic              r_dump_done;

    logic [ADDR_W-1:0] w_addr_next;
    logic              w_accept;
    logic              w_last;

    assign w_addr_next = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_accept    = r_out_valid & out_ready;
    assign w_last      = (r_rem == 16'd1);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_rem         <= '0;
            r_mem_rd_addr <= '0;
            r_out_valid   <= 1'b0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
            r_test_normal <= 1'b0;
            r_dump_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && core_done) begin
                        r_addr        <= base_addr;
                        r_rem         <= count;
                        r_busy        <= 1'b1;
                        r_test_normal <= 1'b1;
                        if (count == 16'd0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state       <= S_ISSUE;
                            r_mem_rd_addr <= base_addr;
                        end
                    end
                end
                S_ISSUE: begin
                    // Combinational memory returns data in the same cycle as the address.
                    if (RD_LAT == 0) begin
                        r_out_data  <= mem_rd_data;
                        r_out_addr  <= r_addr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_PRESENT;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_out_data  <= mem_rd_data;
                    r_out_addr  <= r_addr;
                    r_out_valid <= 1'b1;
                    r_state     <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_addr      <= w_addr_next;
                        r_rem       <= r_rem - 16'd1;
                        if (w_last) begin
                            r_state     <= S_FIN;
                            r_dump_done <= 1'b1;
                        end else begin
                            r_state       <= S_ISSUE;
                            r_mem_rd_addr <= w_addr_next;
                        end
                    end
                end
                S_FIN: begin
                    // An empty dump arrives here without the pulse armed; raise it first.
                    if (!r_dump_done) begin
                        r_dump_done <= 1'b1;
                    end else begin
                        r_dump_done   <= 1'b0;
                        r_busy        <= 1'b0;
                        r_test_normal <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_test_normal = r_test_normal;
    assign mem_rd_addr     = r_mem_rd_addr;
    assign out_valid       = r_out_valid;
    assign out_addr        = r_out_addr;
    assign out_data        = r_out_data;
    assign busy            = r_busy;
    assign dump_done       = r_dump_done;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_readback
// Purpose  : Self-checking bench: vector table plus scoreboard of expected
//            (address, word) pairs, with hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_readback;

    logic        clk;
    logic        clr;
    logic        start;
    logic        core_done;
    logic [15:0] base_addr;
    logic [15:0] count;
    logic        mem_test_normal;
    logic [15:0] mem_rd_addr;
    logic [15:0] mem_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_addr;
    logic [15:0] out_data;
    logic        busy;
    logic        dump_done;

    data_mem_readback #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) dut (
        .clk             (clk),
        .clr             (clr),
        .start           (start),
        .core_done       (core_done),
        .base_addr       (base_addr),
        .count           (count),
        .mem_test_normal (mem_test_normal),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .busy            (busy),
        .dump_done       (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with one-clock registered read.
    logic [15:0] mem [0:65535];
    always @(posedge clk) mem_rd_data <= mem[mem_rd_addr];

    typedef struct {
        logic [15:0] base;
        logic [15:0] cnt;
        int          stall;
        logic        poke;
        logic [15:0] pa;
        logic [15:0] pd;
        logic        spur;
    } vec_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t sbq[$];
    vec_t vt[6];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tn"},    {31'd0, mem_test_normal}, 32'd0);
        chk({tag, "_rdaddr"}, {16'd0, mem_rd_addr},    32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid},       32'd0);
        chk({tag, "_oaddr"}, {16'd0, out_addr},        32'd0);
        chk({tag, "_odata"}, {16'd0, out_data},        32'd0);
        chk({tag, "_busy"},  {31'd0, busy},            32'd0);
        chk({tag, "_done"},  {31'd0, dump_done},       32'd0);
    endtask

    task automatic run_dump(input vec_t v);
        int          cyc;
        int          st;
        logic        prev_stall;
        logic [15:0] pa_;
        logic [15:0] pd_;
        exp_t        e;
        logic        done;
        if (v.poke) mem[v.pa] = v.pd;
        for (int i = 0; i < int'(v.cnt); i++) begin
            e.a = v.base + 16'(i);
            e.d = mem[e.a];
            sbq.push_back(e);
        end
        base_addr = v.base;
        count     = v.cnt;
        core_done = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        core_done = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("tn_after_start", {31'd0, mem_test_normal}, 32'd1);
        cyc = 1; st = 0; prev_stall = 1'b0; done = 1'b0; pa_ = '0; pd_ = '0;
        while (cyc < 400) begin
            if (dump_done === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (v.spur && cyc == 2) begin
                base_addr = v.base + 16'h0100;
                count     = 16'd5;
                core_done = 1'b1;
                start     = 1'b1;
            end else begin
                start     = 1'b0;
                core_done = 1'b0;
            end
            chk("busy_tn_hold", {30'd0, busy, mem_test_normal}, 32'd3);
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    chk("stall_addr", {16'd0, out_addr}, {16'd0, pa_});
                    chk("stall_data", {16'd0, out_data}, {16'd0, pd_});
                end
                if (st < v.stall) begin
                    out_ready  = 1'b0;
                    st++;
                    prev_stall = 1'b1;
                    pa_        = out_addr;
                    pd_        = out_data;
                end else begin
                    out_ready  = 1'b1;
                    st         = 0;
                    prev_stall = 1'b0;
                    chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        chk("word_addr", {16'd0, out_addr}, {16'd0, e.a});
                        chk("word_data", {16'd0, out_data}, {16'd0, e.d});
                    end
                end
            end else begin
                out_ready  = 1'b0;
                prev_stall = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        core_done = 1'b0;
        out_ready = 1'b0;
        chk("dump_done_seen", {31'd0, done}, 32'd1);
        chk("words_left", sbq.size(), 32'd0);
        sbq.delete();
        if (v.stall == 0) chk("latency", cyc, 3 * int'(v.cnt) + 1);
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        chk("valid_at_done", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, dump_done}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("tn_fall", {31'd0, mem_test_normal}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        vec_t v;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7) ^ 16'h5A3C;
        mem[16'h0000] = 16'h0047;
        mem[16'h0001] = 16'h0089;
        mem[16'hFFFF] = 16'h1234;

        //          base      cnt    stall poke  pa        pd        spur
        vt[0] = '{16'h0000, 16'd2, 0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[1] = '{16'h0010, 16'd3, 5, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[2] = '{16'hFFFF, 16'd2, 0, 1'b1, 16'h0000, 16'hABCD, 1'b0};
        vt[3] = '{16'hFFFE, 16'd3, 1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vt[4] = '{16'h0200, 16'd2, 0, 1'b0, 16'h0000, 16'h0000, 1'b1};
        vt[5] = '{16'h0300, 16'd4, 2, 1'b0, 16'h0000, 16'h0000, 1'b0};

        clr = 1'b1; start = 1'b0; core_done = 1'b0;
        base_addr = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        clr = 1'b0;
        @(negedge clk);

        // start without core_done is ignored
        base_addr = 16'h0123; count = 16'd1; core_done = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("nodone_busy", {31'd0, busy}, 32'd0);
            chk("nodone_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 6; i++) run_dump(vt[i]);

        // count == 0: busy for two cycles, pulse on the second, never valid
        base_addr = 16'h0777; count = 16'd0; core_done = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; core_done = 1'b0;
        chk("c0_busy1", {31'd0, busy}, 32'd1);
        chk("c0_done1", {31'd0, dump_done}, 32'd0);
        chk("c0_valid1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("c0_busy2", {31'd0, busy}, 32'd1);
        chk("c0_done2", {31'd0, dump_done}, 32'd1);
        chk("c0_valid2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("c0_busy3", {31'd0, busy}, 32'd0);
        chk("c0_done3", {31'd0, dump_done}, 32'd0);
        chk("c0_tn3", {31'd0, mem_test_normal}, 32'd0);

        // clr while word 2 of 4 is presented
        base_addr = 16'h0400; count = 16'd4; core_done = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; core_done = 1'b0; out_ready = 1'b1;
        w = 0;
        while (out_valid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        chk("clr_w1_seen", {31'd0, out_valid}, 32'd1);
        chk("clr_w1_data", {16'd0, out_data}, {16'd0, mem[16'h0400]});
        @(negedge clk);
        out_ready = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 10) begin @(negedge clk); w++; end
        chk("clr_w2_seen", {31'd0, out_valid}, 32'd1);
        chk("clr_w2_addr", {16'd0, out_addr}, 32'h0401);
        clr = 1'b1;
        #1;
        check_all_zero("clr_mid");
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_clr_done", {31'd0, dump_done}, 32'd0);
            chk("post_clr_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end
        v = '{16'h0500, 16'd2, 0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        run_dump(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_readback.md
Name: data_mem_readback

Overview:
- Hardware reader for the Single_Cycle_RISC external data-memory port. It is the counterpart to the bench-side writer that loads memory through ext_data_we/ext_data_addr/ext_data_data.
- After the core asserts done, it holds the core in test mode, reads a contiguous range of data memory and streams each (address, word) pair out over a valid/ready interface.
- Used for post-run checking of STR results in silicon and in simulation, without hierarchical peeks.

Parameters:
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data-memory word width.
- RD_LAT, 1, data-memory read latency in clocks, counted from mem_rd_addr valid to mem_rd_data valid. Legal values are 0 or 1.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- core_done  in  1  core's done output; a dump begins only when start=1 and core_done=1.
- base_addr  in  ADDR_W  first address to read; captured on accepted start.
- count  in  16  number of words to read; captured on accepted start.
- mem_test_normal  out  1  forces the core/memory into test mode (ORed with the bench test_normal at top level).
- mem_rd_addr  out  ADDR_W  data-memory read address.
- mem_rd_data  in  DATA_W  data-memory read data.
- out_valid  out  1  stream word valid.
- out_ready  in  1  downstream accept.
- out_addr  out  ADDR_W  address of the presented word.
- out_data  out  DATA_W  presented word.
- busy  out  1  high from accepted start until the dump_done pulse (inclusive).
- dump_done  out  1  one-cycle pulse when the last word is accepted, or immediately when count=0.

Behaviour:
- Reset (clr=1, async): state=IDLE. All outputs are 0: mem_test_normal, mem_rd_addr, out_valid, out_addr, out_data, busy, dump_done. Internal address and remaining-word counters are 0.
- IDLE:
  - start=1 with core_done=1 captures base_addr into addr_r and count into rem_r, sets busy=1 and mem_test_normal=1 on the next edge.
  - If count=0, go to FIN; otherwise go to ISSUE.
  - start with core_done=0 is ignored, with no state change.
- ISSUE: mem_rd_addr=addr_r for one cycle. If RD_LAT=1, go to WAIT. If RD_LAT=0, capture mem_rd_data this cycle and go to PRESENT.
- WAIT (RD_LAT=1 only): capture mem_rd_data into out_data and addr_r into out_addr, then go to PRESENT.
- PRESENT:
  - out_valid=1. out_addr and out_data are held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: drop out_valid, addr_r<=addr_r+1 (wraps FFFF->0000 at ADDR_W bits), rem_r<=rem_r-1.
  - If rem_r was 1, go to FIN; else go to ISSUE.
- FIN:
  - dump_done=1 for exactly one cycle; busy stays 1 during this cycle.
  - Next edge: busy=0, mem_test_normal=0, state=IDLE.
- Throughput: best case is one word per 3 clocks (RD_LAT=1) or 2 clocks (RD_LAT=0).
- mem_rd_addr holds its last value outside ISSUE. Memory is read only, so mem_rd_addr is don't-care while the module is idle.
- mem_test_normal stays high for the whole dump, including backpressure stalls.
- start while busy is ignored; the captured base_addr and count are unaffected.
- core_done dropping mid-dump does not abort the dump.
- clr mid-dump aborts immediately. No dump_done pulse is issued. out_valid drops asynchronously.
- Address wrap: base_addr=FFFE, count=3 reads FFFE, FFFF, 0000.
- Arithmetic: count is unsigned. The maximum of 65535 words is legal.

Test Plan:
- Preload mem[0]=0047 and mem[1]=0089, run the min/max program to HLT, then start with base=0, count=2 and out_ready=1. Required: stream (0000,0047), then (0001,0089). dump_done pulses once on the second accept; busy falls the next cycle.
- Backpressure: with count=3, hold out_ready=0 for 5 cycles on each word. Required: out_addr and out_data stay stable while stalled, no word is lost or duplicated, and mem_test_normal stays 1 throughout.
- count=0 with start while core_done=1. Required: no out_valid, dump_done pulses 2 cycles after start, and busy is high for exactly those 2 cycles.
- start while core_done=0. Required: state stays IDLE and busy=0. A second start while busy (with different base) is ignored, and the original addresses are streamed.
- Wrap-around: preload mem[FFFF]=1234 and mem[0000]=ABCD, start with base=FFFF, count=2. Required: stream (FFFF,1234), then (0000,ABCD).
- Assert clr during PRESENT of word 2 of 4. Required: all outputs are 0 immediately with no dump_done. A fresh start afterwards restarts cleanly from the new base_addr.
